// File: rtl/ad9958_spi_master.sv
// ad9958_spi_master: autonomous AD9958 loader. Pulses master reset, writes CSR/FR1,
// then streams FTW/ASF for both channels forever with an IO_UPDATE pulse per frame.
`timescale 1ns/1ps
module ad9958_spi_master #(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned IOUP_CYCLES  = 4,
    parameter int unsigned CS_GAP       = 2,
    parameter logic [23:0] FR1_VALUE    = 24'hD00000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ftw_ch0,
    input  logic [31:0] ftw_ch1,
    input  logic [9:0]  asf_ch0,
    input  logic [9:0]  asf_ch1,
    output logic        cs,
    output logic        sclk,
    output logic [3:0]  sdio,
    output logic        master_reset,
    output logic        io_update
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PH_W      = $clog2(2 * CLK_DIV);
    localparam int unsigned BIT_W     = 6;
    localparam int unsigned WORD_W    = 40;
    localparam int unsigned INIT_IDLE = 16;

    // Transaction slots: 0 CSR init, 1 FR1, 2..7 the per-frame writes
    localparam logic [2:0] TXN_CSR_INIT = 3'd0;
    localparam logic [2:0] TXN_FR1      = 3'd1;
    localparam logic [2:0] TXN_FRAME0   = 3'd2;
    localparam logic [2:0] TXN_LAST     = 3'd7;

    typedef enum logic [2:0] {
        ST_RST,
        ST_MRESET,
        ST_INIT_WAIT,
        ST_XFER,
        ST_GAP,
        ST_LOAD,
        ST_IOUP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [PH_W-1:0]     r_ph, w_ph_nxt;
    logic [BIT_W-1:0]    r_bit, w_bit_nxt;
    logic [BIT_W-1:0]    r_nbits, w_nbits_nxt;
    logic [WORD_W-1:0]   r_shift, w_shift_nxt;
    logic [2:0]          r_txn, w_txn_nxt;
    logic [31:0]         r_sh_ftw0, r_sh_ftw1, w_sh_ftw0_nxt, w_sh_ftw1_nxt;
    logic [9:0]          r_sh_asf0, r_sh_asf1, w_sh_asf0_nxt, w_sh_asf1_nxt;
    logic                r_cs, r_sclk, r_sdio0, r_mreset, r_ioup;
    logic                w_cs_nxt, w_sclk_nxt, w_sdio0_nxt, w_mreset_nxt, w_ioup_nxt;
    logic                w_start;
    logic [BIT_W+WORD_W-1:0] w_word;

    assign cs           = r_cs;
    assign sclk         = r_sclk;
    assign sdio         = {3'b000, r_sdio0};
    assign master_reset = r_mreset;
    assign io_update    = r_ioup;

    // Bit count and MSB-aligned instruction+data word for a transaction slot
    function automatic logic [BIT_W+WORD_W-1:0] build_word(
        input logic [2:0]  idx,
        input logic [31:0] f0,
        input logic [31:0] f1,
        input logic [9:0]  a0,
        input logic [9:0]  a1
    );
        logic [BIT_W+WORD_W-1:0] w;
        case (idx)
            3'd0:    w = {6'd16, 8'h00, 8'h00, 24'h000000};
            3'd1:    w = {6'd32, 8'h01, FR1_VALUE, 8'h00};
            3'd2:    w = {6'd16, 8'h00, 8'h40, 24'h000000};
            3'd3:    w = {6'd40, 8'h04, f0};
            3'd4:    w = {6'd32, 8'h06, 8'h00, 6'b000100, a0, 8'h00};
            3'd5:    w = {6'd16, 8'h00, 8'h80, 24'h000000};
            3'd6:    w = {6'd40, 8'h04, f1};
            default: w = {6'd32, 8'h06, 8'h00, 6'b000100, a1, 8'h00};
        endcase
        return w;
    endfunction

    // State and datapath registers; reset restarts the whole sequence
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_RST;
            r_cnt     <= '0;
            r_ph      <= '0;
            r_bit     <= '0;
            r_nbits   <= '0;
            r_shift   <= '0;
            r_txn     <= '0;
            r_sh_ftw0 <= '0;
            r_sh_ftw1 <= '0;
            r_sh_asf0 <= '0;
            r_sh_asf1 <= '0;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b0;
            r_sdio0   <= 1'b0;
            r_mreset  <= 1'b1;
            r_ioup    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ph      <= w_ph_nxt;
            r_bit     <= w_bit_nxt;
            r_nbits   <= w_nbits_nxt;
            r_shift   <= w_shift_nxt;
            r_txn     <= w_txn_nxt;
            r_sh_ftw0 <= w_sh_ftw0_nxt;
            r_sh_ftw1 <= w_sh_ftw1_nxt;
            r_sh_asf0 <= w_sh_asf0_nxt;
            r_sh_asf1 <= w_sh_asf1_nxt;
            r_cs      <= w_cs_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sdio0   <= w_sdio0_nxt;
            r_mreset  <= w_mreset_nxt;
            r_ioup    <= w_ioup_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ph_nxt      = r_ph;
        w_bit_nxt     = r_bit;
        w_nbits_nxt   = r_nbits;
        w_shift_nxt   = r_shift;
        w_txn_nxt     = r_txn;
        w_sh_ftw0_nxt = r_sh_ftw0;
        w_sh_ftw1_nxt = r_sh_ftw1;
        w_sh_asf0_nxt = r_sh_asf0;
        w_sh_asf1_nxt = r_sh_asf1;
        w_cs_nxt      = r_cs;
        w_sclk_nxt    = r_sclk;
        w_sdio0_nxt   = r_sdio0;
        w_mreset_nxt  = r_mreset;
        w_ioup_nxt    = r_ioup;
        w_start       = 1'b0;
        w_word        = '0;

        case (r_state)
            ST_RST: begin
                w_state_nxt  = ST_MRESET;
                w_cnt_nxt    = CNT_W'(1);
                w_mreset_nxt = 1'b1;
            end
            ST_MRESET: begin
                if (r_cnt >= CNT_W'(RESET_CYCLES - 1)) begin
                    w_mreset_nxt = 1'b0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = ST_INIT_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_INIT_WAIT: begin
                if (r_cnt == CNT_W'(INIT_IDLE - 1)) begin
                    w_start   = 1'b1;
                    w_txn_nxt = TXN_CSR_INIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_XFER: begin
                if (r_ph == PH_W'(2 * CLK_DIV - 1)) begin
                    // Falling SCLK: advance to the next bit or close the transaction
                    w_ph_nxt   = '0;
                    w_sclk_nxt = 1'b0;
                    if (r_bit == r_nbits - BIT_W'(1)) begin
                        w_cs_nxt    = 1'b1;
                        w_sdio0_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_sdio0_nxt = r_shift[WORD_W-1];
                        w_shift_nxt = {r_shift[WORD_W-2:0], 1'b0};
                    end
                end else begin
                    w_ph_nxt = r_ph + PH_W'(1);
                    if (r_ph == PH_W'(CLK_DIV - 1)) begin
                        w_sclk_nxt = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (r_cnt >= CNT_W'(CS_GAP - 1)) begin
                    if (r_txn == TXN_FR1) begin
                        w_state_nxt = ST_LOAD;
                    end else if (r_txn == TXN_LAST) begin
                        w_ioup_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_IOUP;
                    end else begin
                        w_start   = 1'b1;
                        w_txn_nxt = r_txn + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                // Snapshot inputs; the frame's first write (CSR) needs no shadow data
                w_sh_ftw0_nxt = ftw_ch0;
                w_sh_ftw1_nxt = ftw_ch1;
                w_sh_asf0_nxt = asf_ch0;
                w_sh_asf1_nxt = asf_ch1;
                w_start       = 1'b1;
                w_txn_nxt     = TXN_FRAME0;
            end
            ST_IOUP: begin
                if (r_cnt >= CNT_W'(IOUP_CYCLES - 1)) begin
                    w_ioup_nxt  = 1'b0;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase

        // Transaction start: CS falls with the MSB already on SDIO
        if (w_start) begin
            w_word      = build_word(w_txn_nxt, r_sh_ftw0, r_sh_ftw1, r_sh_asf0, r_sh_asf1);
            w_state_nxt = ST_XFER;
            w_cs_nxt    = 1'b0;
            w_sclk_nxt  = 1'b0;
            w_ph_nxt    = '0;
            w_bit_nxt   = '0;
            w_nbits_nxt = w_word[BIT_W+WORD_W-1:WORD_W];
            w_sdio0_nxt = w_word[WORD_W-1];
            w_shift_nxt = {w_word[WORD_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_ad9958_spi_master.sv
// tb_ad9958_spi_master: decodes every CS window on SCLK rises and compares it
// against words built from the inputs seen at each frame's load edge.
`timescale 1ns/1ps
module tb_ad9958_spi_master;

    localparam int unsigned CLK_DIV      = 2;
    localparam int unsigned RESET_CYCLES = 16;
    localparam int unsigned IOUP_CYCLES  = 4;
    localparam int unsigned CS_GAP       = 2;
    localparam logic [23:0] FR1_VALUE    = 24'hD00000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ftw_ch0 = '0;
    logic [31:0] ftw_ch1 = '0;
    logic [9:0]  asf_ch0 = '0;
    logic [9:0]  asf_ch1 = '0;
    logic        cs, sclk, master_reset, io_update;
    logic [3:0]  sdio;

    typedef struct packed {
        logic [5:0]  bits;
        logic [39:0] val;
    } win_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    win_t exp_q[$];
    win_t dec_q[$];
    int   io_w_q[$];
    int   io_d_q[$];
    bit   inc_en = 1'b0;

    always #5 clock = ~clock;

    ad9958_spi_master #(
        .CLK_DIV(CLK_DIV),
        .RESET_CYCLES(RESET_CYCLES),
        .IOUP_CYCLES(IOUP_CYCLES),
        .CS_GAP(CS_GAP),
        .FR1_VALUE(FR1_VALUE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ftw_ch0(ftw_ch0),
        .ftw_ch1(ftw_ch1),
        .asf_ch0(asf_ch0),
        .asf_ch1(asf_ch1),
        .cs(cs),
        .sclk(sclk),
        .sdio(sdio),
        .master_reset(master_reset),
        .io_update(io_update)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected decoded window (right-aligned) for a position in the sequence
    function automatic win_t model(input int p, input logic [31:0] f0, input logic [31:0] f1,
                                   input logic [9:0] a0, input logic [9:0] a1);
        win_t w;
        case (p)
            0:       w = {6'd16, 40'h0};
            1:       w = {6'd32, 8'h00, 8'h01, FR1_VALUE};
            2:       w = {6'd16, 40'h40};
            3:       w = {6'd40, 8'h04, f0};
            4:       w = {6'd32, 8'h00, 8'h06, 8'h00, 6'b000100, a0};
            5:       w = {6'd16, 40'h80};
            6:       w = {6'd40, 8'h04, f1};
            default: w = {6'd32, 8'h00, 8'h06, 8'h00, 6'b000100, a1};
        endcase
        return w;
    endfunction

    // Bus monitor: decode windows, push expectations, protocol checks
    logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_sdio0 = 1'b0, prev_io = 1'b0;
    int          bits = 0, win_idx = 0, since_cs = 0, io_w = 0, pos = 0;
    logic [39:0] sh = '0;
    logic [31:0] s_f0 = '0, s_f1 = '0;
    logic [9:0]  s_a0 = '0, s_a1 = '0;

    always @(posedge clock) begin
        #1;
        if (reset) begin
            win_idx  = 0;
            bits     = 0;
            sh       = '0;
            io_w     = 0;
            since_cs = 0;
        end else begin
            since_cs++;
            if (cs === 1'b1) check("sclk_idle_cs_high", 64'(sclk), 64'd0);
            check("sdio_upper_zero", 64'(sdio[3:1]), 64'd0);
            if (sdio[0] !== prev_sdio0)
                check("sdio_change_edge",
                      64'((prev_sclk && !sclk) || (prev_cs && !cs) || (!prev_cs && cs)), 64'd1);
            if (prev_cs && !cs) begin
                bits = 0;
                sh   = '0;
                pos  = (win_idx < 2) ? win_idx : 2 + (win_idx - 2) % 6;
                if (pos == 2) begin
                    s_f0 = ftw_ch0;
                    s_f1 = ftw_ch1;
                    s_a0 = asf_ch0;
                    s_a1 = asf_ch1;
                end
                exp_q.push_back(model(pos, s_f0, s_f1, s_a0, s_a1));
            end
            if (!cs && !prev_sclk && sclk) begin
                sh = {sh[38:0], sdio[0]};
                bits++;
            end
            if (!prev_cs && cs) begin
                check("window_bits", 64'((bits == 16) || (bits == 32) || (bits == 40)), 64'd1);
                dec_q.push_back({6'(bits), sh});
                win_idx++;
                since_cs = 0;
            end
            if (io_update) io_w++;
            if (!prev_io && io_update) io_d_q.push_back(since_cs);
            if (prev_io && !io_update) begin
                io_w_q.push_back(io_w);
                io_w = 0;
            end
        end
        prev_cs    = cs;
        prev_sclk  = sclk;
        prev_sdio0 = sdio[0];
        prev_io    = io_update;
    end

    // One cycle: optional input ramp on the falling edge, sample after the monitor
    task tick();
        @(negedge clock);
        if (inc_en) begin
            ftw_ch0 = ftw_ch0 + 32'd500;
            ftw_ch1 = ftw_ch1 + 32'd500;
            asf_ch0 = asf_ch0 + 10'd1000;
            asf_ch1 = asf_ch1 + 10'd1000;
        end
        @(posedge clock);
        #2;
    endtask

    task automatic release_and_measure(input string tag);
        int k;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #2;
        k = 1;
        while (master_reset !== 1'b0 && k < 100) begin
            tick();
            k++;
        end
        check(tag, 64'(k), 64'(RESET_CYCLES));
    endtask

    task automatic cmp_win(input string tag, output win_t got);
        int t;
        win_t e;
        got = '0;
        t = 0;
        while (dec_q.size() == 0 && t < 1000) begin
            tick();
            t++;
        end
        if (dec_q.size() == 0) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        got = dec_q.pop_front();
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check(tag, 64'(got), 64'(e));
    endtask

    task automatic cmp_io(input string tag);
        int t;
        int d;
        t = 0;
        while (io_w_q.size() == 0 && t < 1000) begin
            tick();
            t++;
        end
        if (io_w_q.size() == 0) begin
            check({tag, "_timeout"}, 64'd0, 64'd1);
            return;
        end
        d = (io_d_q.size() > 0) ? io_d_q.pop_front() : -1;
        check({tag, "_width"}, 64'(io_w_q.pop_front()), 64'(IOUP_CYCLES));
        check({tag, "_delay"}, 64'(d), 64'(CS_GAP));
    endtask

    task automatic cmp_frame(input string tag);
        win_t w;
        for (int i = 0; i < 6; i++) cmp_win(tag, w);
        cmp_io({tag, "_io"});
    endtask

    logic [45:0] lit [6];

    initial begin
        win_t w;
        int   t;
        lit[0] = {6'd16, 40'h0000000040};
        lit[1] = {6'd40, 40'h0412345678};
        lit[2] = {6'd32, 40'h00060013FF};
        lit[3] = {6'd16, 40'h0000000080};
        lit[4] = {6'd40, 40'h049ABCDEF0};
        lit[5] = {6'd32, 40'h0006001155};

        reset   = 1'b1;
        ftw_ch0 = 32'h12345678;
        ftw_ch1 = 32'h9ABCDEF0;
        asf_ch0 = 10'h3FF;
        asf_ch1 = 10'h155;

        // Outputs held at reset values
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_outputs", 64'({cs, sclk, sdio, master_reset, io_update}), 64'(8'b1000_0010));
        end

        release_and_measure("mreset_len");

        cmp_win("init_csr", w);
        cmp_win("init_fr1", w);
        check("init_fr1_literal", 64'(w), 64'({6'd32, 40'h0001D00000}));

        // Constant inputs: first frame against literal words
        for (int i = 0; i < 6; i++) begin
            cmp_win("frame1", w);
            check("frame1_literal", 64'(w), 64'(lit[i]));
        end
        cmp_io("frame1_io");

        // Inputs ramp every cycle; each frame must reflect its load-edge snapshot
        inc_en = 1'b1;
        for (int f = 0; f < 3; f++) cmp_frame("ramp");

        // Reset in the middle of a CFTW0 transfer
        t = 0;
        while (!(cs === 1'b0 && bits >= 12 && win_idx >= 2 &&
                 ((win_idx - 2) % 6 == 1 || (win_idx - 2) % 6 == 4)) && t < 2000) begin
            tick();
            t++;
        end
        check("reach_cftw0", 64'(t < 2000), 64'd1);
        inc_en = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #2;
        check("mid_reset_outputs", 64'({cs, sclk, master_reset, io_update}), 64'(4'b1010));
        exp_q.delete();
        dec_q.delete();
        io_w_q.delete();
        io_d_q.delete();
        tick();
        tick();
        ftw_ch0 = 32'hCAFE0001;
        ftw_ch1 = 32'h0BAD0002;
        asf_ch0 = 10'h001;
        asf_ch1 = 10'h200;
        release_and_measure("restart_mreset_len");
        cmp_win("restart_csr", w);
        cmp_win("restart_fr1", w);
        check("restart_fr1_literal", 64'(w), 64'({6'd32, 40'h0001D00000}));
        cmp_frame("restart");

        // Longer ramped run with continuous protocol monitoring
        inc_en = 1'b1;
        for (int f = 0; f < 5; f++) cmp_frame("soak");
        inc_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
